// File: rtl/uart_frame_ctrl.sv
// rtl/uart_frame_ctrl.sv - 6-byte command frame sequencer with checksum, inter-byte timeout and write strobe
module uart_frame_ctrl #(
    parameter int          CLK_FRE     = 50_000_000,
    parameter int          TIMEOUT_CNT = 50_000,
    parameter logic [7:0]  HEAD0       = 8'h55,
    parameter logic [7:0]  HEAD1       = 8'hA5
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy
);

    if (CLK_FRE < 1 || TIMEOUT_CNT < 2 || TIMEOUT_CNT > 24'hFF_FFFF) begin : g_param_check
        $error("uart_frame_ctrl: parameter out of range");
    end

    localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAD1,
        S_ADDR,
        S_DATH,
        S_DATL,
        S_CHK
    } state_t;

    state_t      state_q,     state_d;
    logic [7:0]  sum_q,       sum_d;
    logic [23:0] cnt_q,       cnt_d;
    logic [7:0]  addr_sh_q,   addr_sh_d;
    logic [7:0]  dath_sh_q,   dath_sh_d;
    logic [7:0]  datl_sh_q,   datl_sh_d;
    logic        wr_en_q,     wr_en_d;
    logic [7:0]  wr_addr_q,   wr_addr_d;
    logic [15:0] wr_data_q,   wr_data_d;
    logic        frame_err_q, frame_err_d;
    logic [1:0]  err_code_q,  err_code_d;
    logic        busy_q,      busy_d;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            sum_q       <= 8'h00;
            cnt_q       <= 24'd0;
            addr_sh_q   <= 8'h00;
            dath_sh_q   <= 8'h00;
            datl_sh_q   <= 8'h00;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 8'h00;
            wr_data_q   <= 16'h0000;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'b00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            addr_sh_q   <= addr_sh_d;
            dath_sh_q   <= dath_sh_d;
            datl_sh_q   <= datl_sh_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        addr_sh_d   = addr_sh_q;
        dath_sh_d   = dath_sh_q;
        datl_sh_d   = datl_sh_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;

        if (state_q == S_IDLE || rx_done) begin
            cnt_d = 24'd0;
        end else begin
            cnt_d = cnt_q + 24'd1;
        end

        // A byte landing on the terminal-count cycle takes priority over the timeout.
        if (rx_done) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == HEAD0) begin
                        state_d = S_HEAD1;
                        sum_d   = 8'h00;
                    end
                end
                S_HEAD1: begin
                    if (rx_data == HEAD1) begin
                        state_d = S_ADDR;
                    end else if (rx_data == HEAD0) begin
                        state_d = S_HEAD1;
                        sum_d   = 8'h00;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ADDR: begin
                    addr_sh_d = rx_data;
                    sum_d     = sum_q + rx_data;
                    state_d   = S_DATH;
                end
                S_DATH: begin
                    dath_sh_d = rx_data;
                    sum_d     = sum_q + rx_data;
                    state_d   = S_DATL;
                end
                S_DATL: begin
                    datl_sh_d = rx_data;
                    sum_d     = sum_q + rx_data;
                    state_d   = S_CHK;
                end
                S_CHK: begin
                    if (rx_data == sum_q) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_sh_q;
                        wr_data_d = {dath_sh_q, datl_sh_q};
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'b01;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && cnt_q == TO_LAST) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'b10;
            state_d     = S_IDLE;
            cnt_d       = 24'd0;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb/tb_uart_frame_ctrl.sv - directed scoreboard bench for uart_frame_ctrl
module tb_uart_frame_ctrl;

    localparam int TO = 100;

    logic        sys_clk;
    logic        sys_rst;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;

    uart_frame_ctrl #(
        .CLK_FRE     (50_000_000),
        .TIMEOUT_CNT (TO),
        .HEAD0       (8'h55),
        .HEAD1       (8'hA5)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit          is_err;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [1:0]  code;
    } ev_t;

    ev_t exp_q[$];
    int  errors    = 0;
    int  checks    = 0;
    int  wr_seen   = 0;
    int  err_seen  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [15:0] d);
        ev_t e;
        e.is_err = 1'b0; e.addr = a; e.data = d; e.code = 2'b00;
        exp_q.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] c);
        ev_t e;
        e.is_err = 1'b1; e.addr = 8'h00; e.data = 16'h0000; e.code = c;
        exp_q.push_back(e);
    endtask

    // Called just after a rising edge; leaves the byte captured at the next edge.
    task automatic drive(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge sys_clk);
        #1;
    endtask

    always @(negedge sys_clk) begin
        if (!sys_rst && (wr_en || frame_err)) begin
            ev_t e;
            if (wr_en) wr_seen++;
            if (frame_err) err_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {30'd0, wr_en, frame_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", {30'd0, wr_en, frame_err}, e.is_err ? 32'd1 : 32'd2);
                if (e.is_err) begin
                    check("err_code", {30'd0, err_code}, {30'd0, e.code});
                end else begin
                    check("wr_addr", {24'd0, wr_addr}, {24'd0, e.addr});
                    check("wr_data", {16'd0, wr_data}, {16'd0, e.data});
                end
            end
        end
    end

    initial begin
        sys_rst = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {16'd0, wr_data}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_err_code", {30'd0, err_code}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;

        // Valid frame
        push_wr(8'h12, 16'h3456);
        drive(8'h55);
        check("busy_rise", {31'd0, busy}, 32'd1);
        drive(8'hA5); drive(8'h12); drive(8'h34); drive(8'h56); drive(8'h9C);
        rx_done = 1'b0;
        check("valid_wr_en_lat", {31'd0, wr_en}, 32'd1);
        check("valid_no_err", {31'd0, frame_err}, 32'd0);
        check("valid_busy_fall", {31'd0, busy}, 32'd0);
        check("valid_addr", {24'd0, wr_addr}, 32'h12);
        check("valid_data", {16'd0, wr_data}, 32'h3456);

        // Bad checksum, back-to-back with the previous frame
        push_err(2'b01);
        drive(8'h55); drive(8'hA5); drive(8'h12); drive(8'h34); drive(8'h56); drive(8'h00);
        rx_done = 1'b0;
        check("chk_err_lat", {31'd0, frame_err}, 32'd1);
        check("chk_err_code", {30'd0, err_code}, 32'd1);
        check("chk_no_wr", {31'd0, wr_en}, 32'd0);
        check("chk_addr_held", {24'd0, wr_addr}, 32'h12);
        check("chk_data_held", {16'd0, wr_data}, 32'h3456);

        // Resync on repeated header and checksum wrap
        push_wr(8'hFF, 16'h8002);
        drive(8'h00); drive(8'h55); drive(8'h55); drive(8'hA5);
        drive(8'hFF); drive(8'h80); drive(8'h02); drive(8'h81);
        rx_done = 1'b0;
        check("wrap_wr_en", {31'd0, wr_en}, 32'd1);
        check("wrap_addr", {24'd0, wr_addr}, 32'hFF);
        check("wrap_data", {16'd0, wr_data}, 32'h8002);

        // Timeout after ADDR
        push_err(2'b10);
        drive(8'h55); drive(8'hA5); drive(8'h12);
        rx_done = 1'b0;
        repeat (TO - 1) @(posedge sys_clk);
        #1;
        check("to_not_early", {31'd0, frame_err}, 32'd0);
        check("to_busy_before", {31'd0, busy}, 32'd1);
        @(posedge sys_clk);
        #1;
        check("to_err", {31'd0, frame_err}, 32'd1);
        check("to_code", {30'd0, err_code}, 32'd2);
        check("to_busy", {31'd0, busy}, 32'd0);
        check("to_addr_held", {24'd0, wr_addr}, 32'hFF);
        @(posedge sys_clk);
        #1;

        push_wr(8'h34, 16'h1200);
        drive(8'h55); drive(8'hA5); drive(8'h34); drive(8'h12); drive(8'h00); drive(8'h46);
        rx_done = 1'b0;
        check("post_to_wr_en", {31'd0, wr_en}, 32'd1);

        // Byte arrives exactly on the terminal-count cycle
        push_wr(8'h21, 16'h0304);
        drive(8'h55); drive(8'hA5); drive(8'h21);
        rx_done = 1'b0;
        repeat (TO - 1) @(posedge sys_clk);
        #1;
        drive(8'h03);
        rx_done = 1'b0;
        check("bnd_no_err", {31'd0, frame_err}, 32'd0);
        check("bnd_busy", {31'd0, busy}, 32'd1);
        drive(8'h04); drive(8'h28);
        rx_done = 1'b0;
        check("bnd_wr_en", {31'd0, wr_en}, 32'd1);
        check("bnd_data", {16'd0, wr_data}, 32'h0304);

        // Reset mid-frame
        @(posedge sys_clk);
        #1;
        drive(8'h55); drive(8'hA5); drive(8'h12);
        rx_done = 1'b0;
        sys_rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_addr", {24'd0, wr_addr}, 32'd0);
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        drive(8'h34); drive(8'h56); drive(8'h9C);
        rx_done = 1'b0;
        check("after_rst_no_wr", {31'd0, wr_en}, 32'd0);
        check("after_rst_no_err", {31'd0, frame_err}, 32'd0);
        repeat (2) @(posedge sys_clk);
        #1;
        check("after_rst_addr", {24'd0, wr_addr}, 32'd0);
        check("after_rst_data", {16'd0, wr_data}, 32'd0);
        check("after_rst_code", {30'd0, err_code}, 32'd0);
        check("after_rst_busy", {31'd0, busy}, 32'd0);

        check("queue_drained", exp_q.size(), 32'd0);
        check("wr_pulse_count", wr_seen, 32'd4);
        check("err_pulse_count", err_seen, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_frame_ctrl.md
# uart_frame_ctrl

Frame-level controller that sits directly behind the UART byte receiver. It consumes the `rx_data`/`rx_done` byte stream and sequences bytes through a fixed 6-byte command frame (2-byte header, address, 16-bit data, checksum). It enforces an inter-byte timeout and issues one register-write strobe per valid frame to the downstream configuration register bank. Malformed or stalled frames are dropped and reported.

## Interface
- `CLK_FRE`, 50_000_000, system clock frequency in Hz (documentation only; timeout is set by `TIMEOUT_CNT`)
- `TIMEOUT_CNT`, 50_000, inter-byte timeout in `sys_clk` cycles (1 ms at 50 MHz); legal range 2 to 2^24-1
- `HEAD0`, 8'h55, first header byte
- `HEAD1`, 8'hA5, second header byte

Ports:
- `sys_clk` input 1: system clock; all logic is on the rising edge
- `sys_rst` input 1: reset, asynchronous and active-high
- `rx_data` input 8: received byte; valid only while `rx_done` = 1
- `rx_done` input 1: single-cycle byte-valid strobe from the byte receiver
- `wr_en` output 1: single-cycle write strobe for a valid frame
- `wr_addr` output 8: register address; held until the next valid frame
- `wr_data` output 16: register data, {DATA_H, DATA_L}; held until the next valid frame
- `frame_err` output 1: single-cycle error strobe
- `err_code` output 2: error cause, 2'b01 = checksum, 2'b10 = timeout; held until the next error
- `busy` output 1: 1 whenever the FSM is not in S_IDLE

## Operation
- Frame format: HEAD0, HEAD1, ADDR, DATA_H, DATA_L, CHK.
  - CHK = (ADDR + DATA_H + DATA_L) mod 256.
  - The running sum is an 8-bit accumulator that wraps on overflow and is cleared on entry to S_HEAD1.
- FSM states: S_IDLE, S_HEAD1, S_ADDR, S_DATH, S_DATL, S_CHK. The FSM advances only on cycles where `rx_done` = 1.
- S_IDLE:
  - `rx_data` == HEAD0 → S_HEAD1.
  - Any other byte is ignored silently (no error).
- S_HEAD1:
  - `rx_data` == HEAD1 → S_ADDR.
  - `rx_data` == HEAD0 → stay in S_HEAD1 (resync).
  - Any other byte → S_IDLE, no error.
- S_ADDR, S_DATH, S_DATL: latch the byte into a shadow register, add it to the sum, and advance to the next state.
- S_CHK:
  - CHK == sum → load `wr_addr`/`wr_data` from the shadow registers and pulse `wr_en`.
  - CHK != sum → pulse `frame_err` with `err_code` = 01.
  - Either way → S_IDLE.
- Shadow registers are internal. `wr_addr`/`wr_data` change only on a valid frame, never on partial or bad frames.
- Timeout counter (24 bits):
  - Cleared to 0 on every `rx_done` and whenever the FSM is in S_IDLE.
  - Otherwise increments by 1 per cycle.
  - On reaching TIMEOUT_CNT-1 outside S_IDLE: pulse `frame_err` with `err_code` = 10, go to S_IDLE, clear the counter.
- Simultaneous `rx_done` and timeout terminal count in the same cycle: `rx_done` wins; the byte is processed and no timeout is raised.
- `frame_err` and `wr_en` are mutually exclusive by construction.

## Timing
- Reset values:
  - `wr_en` = 0, `wr_addr` = 8'h00, `wr_data` = 16'h0000.
  - `frame_err` = 0, `err_code` = 2'b00, `busy` = 0.
  - FSM in S_IDLE; sum and timeout counter = 0.
- Asserting `sys_rst` mid-frame aborts the frame immediately. No strobe is emitted, and the next frame must start from HEAD0.
- Latency: `wr_en` / `frame_err` (checksum case) rise 1 cycle after the `rx_done` cycle carrying CHK. `wr_addr`/`wr_data` update in that same cycle.
- Timeout `frame_err` rises 1 cycle after the counter reaches TIMEOUT_CNT-1, i.e. TIMEOUT_CNT cycles after the last `rx_done` (or after entry into a non-IDLE state).
- All strobes are exactly 1 cycle wide; outputs are registered.
- `busy` is registered:
  - Rises 1 cycle after the HEAD0 `rx_done`.
  - Falls in the same cycle as `wr_en`/`frame_err`.
- Back-to-back frames with `rx_done` on consecutive cycles are accepted; no idle cycles are required between frames.

## Test plan
- Valid frame: send 55 A5 12 34 56 9C → exactly one `wr_en` pulse, 1 cycle after the last `rx_done`; `wr_addr` = 12, `wr_data` = 3456; `frame_err` stays 0; `busy` returns to 0.
- Bad checksum: send 55 A5 12 34 56 00 → `frame_err` pulse with `err_code` = 01; no `wr_en`; `wr_addr`/`wr_data` keep their prior values.
- Resync and wrap: send 00 55 55 A5 FF 80 02 81 → byte 00 ignored, header resyncs; sum FF+80+02 wraps to 81; `wr_en` pulses with `wr_addr` = FF, `wr_data` = 8002.
- Timeout: send 55 A5 12, then no `rx_done` for TIMEOUT_CNT cycles (use TIMEOUT_CNT = 100 in the bench) → `frame_err` with `err_code` = 10 exactly 100 cycles after the last `rx_done`; `busy` = 0. A following valid frame is then accepted normally.
- Boundary: the byte arrives on the cycle the counter hits TIMEOUT_CNT-1 → no timeout, the frame continues and completes with `wr_en`.
- Reset mid-frame: send 55 A5 12, assert `sys_rst` for 3 cycles, then send 34 56 9C → no `wr_en` and no `frame_err`; all outputs at reset values.
